// File: rtl/pipelined_add_sub.sv
// Pipelined two's-complement adder/subtractor: one SliceW-bit slice resolved per stage,
// carry rippled stage to stage, valid/ready flow control with bubble collapsing.
module pipelined_add_sub #(
    parameter int Width  = 32,
    parameter int Stages = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Width-1:0] a,
    input  logic [Width-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Width-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int SliceW = Width / Stages;

    logic [Stages-1:0] valid_q;
    logic [Stages-1:0] carry_q;
    logic [Stages-1:0] load;
    logic [Width-1:0]  word_q [Stages];
    logic [Width-1:0]  bop_q  [Stages];
    logic [Width-1:0]  b_cond;

    // Subtraction is A + ~B + 1; the +1 enters as the carry-in of slice 0.
    assign b_cond = b ^ {Width{sub}};

    generate
        for (genvar gi = 0; gi < Stages; gi++) begin : g_stage
            logic [Width-1:0] word_in;
            logic [Width-1:0] bop_in;
            logic             carry_in;
            logic             valid_in;
            logic [SliceW:0]  slice_sum;
            logic [Width-1:0] word_next;
            logic             valid_reg;
            logic             carry_reg;
            logic [Width-1:0] word_reg;
            logic [Width-1:0] bop_reg;

            if (gi == 0) begin : g_first
                assign word_in  = a;
                assign bop_in   = b_cond;
                assign carry_in = sub;
                assign valid_in = in_valid;
            end else begin : g_follow
                assign word_in  = word_q[gi-1];
                assign bop_in   = bop_q[gi-1];
                assign carry_in = carry_q[gi-1];
                assign valid_in = valid_q[gi-1];
            end

            // A stage can take new contents unless it and every stage after it are full
            // while the output is stalled.
            assign load[gi] = out_ready | ~(&valid_q[Stages-1:gi]);

            assign slice_sum = {1'b0, word_in[gi*SliceW +: SliceW]}
                             + {1'b0, bop_in[gi*SliceW +: SliceW]}
                             + {{SliceW{1'b0}}, carry_in};

            // The word carries finished result bits below this slice and raw A bits above it.
            always_comb begin
                word_next = word_in;
                word_next[gi*SliceW +: SliceW] = slice_sum[SliceW-1:0];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_reg <= 1'b0;
                    carry_reg <= 1'b0;
                    word_reg  <= '0;
                    bop_reg   <= '0;
                end else if (load[gi]) begin
                    valid_reg <= valid_in;
                    if (valid_in) begin
                        carry_reg <= slice_sum[SliceW];
                        word_reg  <= word_next;
                        bop_reg   <= bop_in;
                    end
                end
            end

            assign valid_q[gi] = valid_reg;
            assign carry_q[gi] = carry_reg;
            assign word_q[gi]  = word_reg;
            assign bop_q[gi]   = bop_reg;

            if (gi == Stages - 1) begin : g_last
                logic ovf_next;
                logic ovf_reg;

                // Carry into the MSB recovered from the MSB sum bit and its operand bits.
                assign ovf_next = slice_sum[SliceW]
                                ^ (slice_sum[SliceW-1] ^ word_in[Width-1] ^ bop_in[Width-1]);

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        ovf_reg <= 1'b0;
                    end else if (load[gi] && valid_in) begin
                        ovf_reg <= ovf_next;
                    end
                end

                assign overflow = ovf_reg;
            end
        end
    endgenerate

    assign in_ready  = load[0];
    assign out_valid = valid_q[Stages-1];
    assign result    = word_q[Stages-1];
    assign cout      = carry_q[Stages-1];
    assign zero      = (result == '0);

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Directed checks of pipelined_add_sub (Width=32, Stages=4): reset, add/sub corner cases,
// streaming, backpressure and reset while operations are in flight.
module tb_pipelined_add_sub;

    localparam int W = 32;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;
    logic         zero;

    int           n_pass  = 0;
    int           n_total = 0;
    logic [33:0]  exp_q[$];

    always #5 clk = ~clk;

    pipelined_add_sub #(.Width(W), .Stages(S)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .cout     (cout),
        .overflow (overflow),
        .zero     (zero)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    // Reference: {overflow, cout, result}
    function automatic logic [33:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                          input logic ms);
        logic [31:0] bb;
        logic [32:0] s;
        logic        ov;
        bb = ms ? ~mb : mb;
        s  = {1'b0, ma} + {1'b0, bb} + {32'd0, ms};
        ov = (ma[31] == bb[31]) && (s[31] != ma[31]);
        return {ov, s};
    endfunction

    task automatic run_single(input string tag, input logic [31:0] ta, input logic [31:0] tb_op,
                              input logic ts, input logic [31:0] er, input logic ec,
                              input logic eo);
        int lat;
        check({tag, " in_ready"}, 64'(in_ready), 64'd1);
        a        = ta;
        b        = tb_op;
        sub      = ts;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        lat      = 0;
        while (!out_valid && lat < 10) begin
            tick;
            lat++;
        end
        $display("op %s: a=%h b=%h sub=%0d -> result=%h cout=%0d ovf=%0d zero=%0d after %0d edges",
                 tag, ta, tb_op, ts, result, cout, overflow, zero, lat + 1);
        check({tag, " latency"},  64'(lat),      64'd3);
        check({tag, " result"},   64'(result),   64'(er));
        check({tag, " cout"},     64'(cout),     64'(ec));
        check({tag, " overflow"}, 64'(overflow), 64'(eo));
        check({tag, " zero"},     64'(zero),     64'(er == 32'd0));
        tick;
    endtask

    initial begin
        int          sent;
        int          got;
        int          first_cyc;
        int          last_cyc;
        int          accepts;
        int          stray;
        logic        acc;
        logic        have_snap;
        logic [34:0] snap;
        logic [33:0] e;

        // Reset asserted between clock edges
        #2 rst = 1'b1;
        #1;
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset result",    64'(result),    64'd0);
        check("reset cout",      64'(cout),      64'd0);
        check("reset overflow",  64'(overflow),  64'd0);
        check("reset zero",      64'(zero),      64'd1);
        check("reset in_ready",  64'(in_ready),  64'd1);
        tick;
        tick;
        rst = 1'b0;

        run_single("add_carry",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run_single("sub_neg",     32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_single("sub_ovf",     32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        run_single("add_ovf",     32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);

        // Streaming: 16 back-to-back operations, output always ready
        exp_q.delete();
        sent      = 0;
        got       = 0;
        first_cyc = -1;
        last_cyc  = -1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (sent < 16) begin
                a        = $urandom;
                b        = $urandom;
                sub      = ((sent % 3) == 1);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            acc = in_valid && in_ready;
            if (acc) exp_q.push_back(model(a, b, sub));
            tick;
            if (acc) sent++;
            if (out_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
                $display("stream %0d: result=%h cout=%0d ovf=%0d expected=%h", got, result,
                         cout, overflow, e);
                check($sformatf("stream[%0d]", got), 64'({overflow, cout, result}), 64'(e));
                got++;
            end
        end
        in_valid = 1'b0;
        check("stream count",     64'(got),       64'd16);
        check("stream first cyc", 64'(first_cyc), 64'd3);
        check("stream last cyc",  64'(last_cyc),  64'd18);

        // Backpressure: producer always valid, consumer stalled for 8 cycles
        exp_q.delete();
        accepts   = 0;
        have_snap = 1'b0;
        snap      = '0;
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            a        = 32'h1000_0000 + 32'(cyc);
            b        = 32'(cyc * 3);
            sub      = 1'(cyc & 1);
            in_valid = 1'b1;
            acc      = in_ready;
            if (acc) begin
                exp_q.push_back(model(a, b, sub));
                accepts++;
            end
            tick;
            $display("stall %0d: accepted=%0d out_valid=%0d result=%h", cyc, acc, out_valid,
                     result);
            if (out_valid) begin
                if (!have_snap) begin
                    snap      = {out_valid, overflow, cout, result};
                    have_snap = 1'b1;
                end else begin
                    check($sformatf("stall hold[%0d]", cyc),
                          64'({out_valid, overflow, cout, result}), 64'(snap));
                end
            end
        end
        check("stall accepts",       64'(accepts),  64'd4);
        check("stall in_ready full", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        #1;
        check("full in_ready via out_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
        got      = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (out_valid) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
                $display("drain %0d: result=%h expected=%h", got, result, e[31:0]);
                check($sformatf("drain[%0d]", got), 64'({overflow, cout, result}), 64'(e));
                got++;
            end
            tick;
        end
        check("drain count", 64'(got), 64'd4);

        // Reset with three operations in flight
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a        = 32'(i + 1);
            b        = 32'(i + 10);
            sub      = 1'b0;
            in_valid = 1'b1;
            tick;
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check("midreset out_valid", 64'(out_valid), 64'd0);
        check("midreset in_ready",  64'(in_ready),  64'd1);
        tick;
        rst   = 1'b0;
        stray = 0;
        repeat (6) begin
            tick;
            if (out_valid) stray++;
        end
        $display("after reset: stray results=%0d", stray);
        check("midreset discarded", 64'(stray), 64'd0);

        run_single("post_reset", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
